// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter between the 6809 CPU and the DMA engine.
package sram_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W     = 8;

  // E-low cycle counter saturates here; also its value out of reset.
  localparam logic [7:0] E_CNT_MAX = 8'hff;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU        = 3'd1,
    DMA_SETUP  = 3'd2,
    DMA_STROBE = 3'd3,
    DMA_HOLD   = 3'd4
  } state_e;

  function automatic logic is_dma(input state_e s);
    return (s == DMA_SETUP) || (s == DMA_STROBE) || (s == DMA_HOLD);
  endfunction

endpackage

// File: rtl/e_sync.sv
// Two-flop synchronizer bringing the 6809 E clock into the i_clk domain.
module e_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  // Shift E through two flops; both clear on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_d};
    end
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the 6809 CPU (E-high phase, priority) and a DMA
// requester that may only run a fixed three-cycle access inside the E-low phase.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int E_LOW_CYCLES = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // CPU side
  input  logic              i_cpu_sel,
  input  logic              i_cpu_rw,
  input  logic              i_cpu_e,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  // DMA side
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  // SRAM side
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dout,
  output logic              o_sram_doe,
  input  logic [DATA_W-1:0] i_sram_din,
  output logic              o_WE,
  output logic              o_RE,
  output logic              o_CE,
  output logic              o_CE2
);

  // A DMA access takes three cycles, so it must start at least that far before E can rise.
  localparam int DMA_LIMIT = E_LOW_CYCLES - 3;

  logic              e_s;
  logic [7:0]        e_low_cnt;
  logic              dma_window;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dma_addr_q;
  logic              dma_we_q;
  logic [DATA_W-1:0] dma_wdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  e_sync u_e_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_cpu_e),
    .o_q     (e_s)
  );

  // Count cycles spent in the current E-low phase, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_low_cnt <= E_CNT_MAX;
    end else if (e_s) begin
      e_low_cnt <= 8'd0;
    end else if (e_low_cnt != E_CNT_MAX) begin
      e_low_cnt <= e_low_cnt + 8'd1;
    end
  end

  assign dma_window = (int'(e_low_cnt) < DMA_LIMIT);

  // Next-state decision; CPU wins over DMA and a started DMA access always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (e_s && i_cpu_sel) begin
          state_d = CPU;
        end else if (i_dma_req && !e_s && dma_window) begin
          state_d = DMA_SETUP;
        end
      end
      CPU: begin
        if (!e_s || !i_cpu_sel) begin
          state_d = IDLE;
        end
      end
      DMA_SETUP:  state_d = DMA_STROBE;
      DMA_STROBE: state_d = DMA_HOLD;
      DMA_HOLD:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the DMA command at grant so the requester may change it afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dma_addr_q  <= '0;
      dma_we_q    <= 1'b0;
      dma_wdata_q <= '0;
    end else if (state_q == IDLE && state_d == DMA_SETUP) begin
      dma_addr_q  <= i_dma_addr;
      dma_we_q    <= i_dma_we;
      dma_wdata_q <= i_dma_wdata;
    end
  end

  // Read data is taken at the end of the strobe cycle and held until the next DMA read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dma_rdata_q <= '0;
    end else if (state_q == DMA_STROBE && !dma_we_q) begin
      dma_rdata_q <= i_sram_din;
    end
  end

  // SRAM strobes and bus muxing; everything decodes from state so reset idles the bus at once.
  always_comb begin
    o_WE        = 1'b1;
    o_RE        = 1'b0;
    o_CE        = 1'b1;
    o_CE2       = 1'b0;
    o_sram_doe  = 1'b0;
    o_sram_addr = dma_addr_q;
    o_sram_dout = dma_wdata_q;
    if (state_q == CPU) begin
      o_CE        = 1'b0;
      o_CE2       = 1'b1;
      o_WE        = i_cpu_rw;
      o_RE        = i_cpu_rw;
      o_sram_addr = i_cpu_addr;
      o_sram_dout = i_cpu_wdata;
      o_sram_doe  = ~i_cpu_rw;
    end else if (is_dma(state_q)) begin
      o_CE       = 1'b0;
      o_CE2      = 1'b1;
      o_sram_doe = dma_we_q;
      // Write pulses only in the middle cycle so address and data have setup and hold.
      o_WE = !(dma_we_q && state_q == DMA_STROBE);
      o_RE = !dma_we_q && (state_q == DMA_STROBE || state_q == DMA_HOLD);
    end
  end

  assign o_dma_ack   = (state_q == DMA_HOLD);
  assign o_dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: every DMA request queues its expected ack data,
// and an independent monitor checks each ack the DUT presents.
module tb_sram_arbiter;

  localparam int AW = 15;

  typedef struct {
    logic [7:0] rdata;
    string      name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_sel, cpu_rw, cpu_e;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dout, sram_din;
  logic          sram_doe, s_we, s_re, s_ce, s_ce2;

  logic [7:0] mem [0:(1<<AW)-1];
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  sram_arbiter #(
    .ADDR_W       (AW),
    .E_LOW_CYCLES (20)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cpu_sel   (cpu_sel),
    .i_cpu_rw    (cpu_rw),
    .i_cpu_e     (cpu_e),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_dma_req   (dma_req),
    .i_dma_we    (dma_we),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .o_dma_ack   (dma_ack),
    .o_dma_rdata (dma_rdata),
    .o_sram_addr (sram_addr),
    .o_sram_dout (sram_dout),
    .o_sram_doe  (sram_doe),
    .i_sram_din  (sram_din),
    .o_WE        (s_we),
    .o_RE        (s_re),
    .o_CE        (s_ce),
    .o_CE2       (s_ce2)
  );

  always #5 clk = ~clk;

  // Simple synchronous SRAM model: write while selected with WE low, read combinationally.
  always @(posedge clk) begin
    if (!s_we && !s_ce && s_ce2) mem[sram_addr] <= sram_dout;
  end
  assign sram_din = mem[sram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && dma_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", dma_ack, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({"ack_rdata_", e.name}, dma_rdata, e.rdata);
      end
    end
  end

  task automatic e_high(input int n);
    @(negedge clk);
    cpu_e = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drop E, then wait j more falling edges before returning.
  task automatic e_low(input int j);
    @(negedge clk);
    cpu_e = 1'b0;
    repeat (j) @(negedge clk);
  endtask

  task automatic run_dma(input string name, input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd,
                         input int rise_at, input int fall_at, input bit sel_on_rise,
                         input bit track, output int grant_cyc, output int ack_cyc,
                         output int we_low, output int re_high, output int bad_bus);
    exp_t e;
    int   cyc;
    e.rdata = exp_rd;
    e.name  = name;
    exp_q.push_back(e);
    grant_cyc = 0; ack_cyc = 0; we_low = 0; re_high = 0; bad_bus = 0; cyc = 0;
    dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    while (ack_cyc == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (track && !s_ce) begin
        if (grant_cyc == 0) grant_cyc = cyc;
        if (!s_we) we_low++;
        if (s_re) re_high++;
        if (sram_addr !== addr || sram_doe !== we || s_ce2 !== 1'b1 ||
            (we && sram_dout !== wdata)) bad_bus++;
      end
      if (dma_ack) ack_cyc = cyc;
      if (cyc == rise_at) begin
        cpu_e = 1'b1;
        if (sel_on_rise) cpu_sel = 1'b1;
      end
      if (cyc == fall_at) cpu_e = 1'b0;
    end
    dma_req = 1'b0;
    check({name, "_ack_seen"}, ack_cyc != 0, 1);
  endtask

  initial begin
    int g, a, wl, rh, bb;
    rst_n = 1'b0; cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_e = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Reset state
    #12;
    check("rst_we", s_we, 1);
    check("rst_re", s_re, 0);
    check("rst_ce", s_ce, 1);
    check("rst_ce2", s_ce2, 0);
    check("rst_doe", sram_doe, 0);
    check("rst_ack", dma_ack, 0);
    check("rst_rdata", dma_rdata, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // DMA write early in E-low
    e_high(4);
    e_low(3);
    run_dma("wr1234", 1'b1, 15'h1234, 8'hA5, 8'h00, -1, -1, 1'b0, 1'b1, g, a, wl, rh, bb);
    check("wr_grant_cyc", g, 1);
    check("wr_ack_latency", a - g, 2);
    check("wr_we_low_cycles", wl, 1);
    check("wr_re_high_cycles", rh, 0);
    check("wr_bus_stable", bb, 0);
    // Back-to-back read in the cycle after ack
    run_dma("rd1234", 1'b0, 15'h1234, 8'h00, 8'hA5, -1, -1, 1'b0, 1'b1, g, a, wl, rh, bb);
    check("rd_grant_cyc", g, 2);
    check("rd_ack_latency", a - g, 2);
    check("rd_re_high_cycles", rh, 2);
    check("rd_we_low_cycles", wl, 0);
    check("rd_bus_stable", bb, 0);
    check("mem_1234", mem[15'h1234], 8'hA5);

    // Last allowed start count: granted immediately
    e_high(4);
    e_low(18);
    run_dma("wr_last_ok", 1'b1, 15'h0055, 8'h77, 8'hA5, -1, -1, 1'b0, 1'b1, g, a, wl, rh, bb);
    check("limit_minus1_grant", g, 1);
    // One cycle too late: waits for the next E-low phase
    e_high(4);
    e_low(19);
    run_dma("wr_too_late", 1'b1, 15'h0056, 8'h78, 8'hA5, 12, 18, 1'b0, 1'b1, g, a, wl, rh, bb);
    check("limit_next_phase_grant", g, 21);
    check("mem_0055", mem[15'h0055], 8'h77);
    check("mem_0056", mem[15'h0056], 8'h78);

    // CPU write with DMA pending
    e_high(4);
    cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = 15'h0010; cpu_wdata = 8'h3C;
    dma_we = 1'b1; dma_addr = 15'h0200; dma_wdata = 8'h5A; dma_req = 1'b1;
    repeat (2) @(negedge clk);
    check("cpu_ce", s_ce, 0);
    check("cpu_we", s_we, 0);
    check("cpu_re", s_re, 0);
    check("cpu_addr", sram_addr, 15'h0010);
    check("cpu_dout", sram_dout, 8'h3C);
    check("cpu_doe", sram_doe, 1);
    run_dma("wr0200", 1'b1, 15'h0200, 8'h5A, 8'hA5, -1, 1, 1'b0, 1'b0, g, a, wl, rh, bb);
    cpu_sel = 1'b0;
    check("mem_0010", mem[15'h0010], 8'h3C);
    check("mem_0200", mem[15'h0200], 8'h5A);

    // E rises during a DMA read strobe
    e_high(4);
    cpu_rw = 1'b1; cpu_addr = 15'h0010;
    e_low(3);
    run_dma("rd0200", 1'b0, 15'h0200, 8'h00, 8'h5A, 2, -1, 1'b1, 1'b1, g, a, wl, rh, bb);
    check("erise_ack_cyc", a, 3);
    @(negedge clk);
    check("erise_idle_ce", s_ce, 1);
    @(negedge clk);
    check("erise_cpu_ce", s_ce, 0);
    check("erise_cpu_re", s_re, 1);
    check("erise_cpu_addr", sram_addr, 15'h0010);
    cpu_sel = 1'b0;

    // Reset in the middle of a DMA write strobe
    e_low(3);
    dma_we = 1'b1; dma_addr = 15'h0300; dma_wdata = 8'h99; dma_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rstdma_strobe_we", s_we, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstdma_we", s_we, 1);
    check("rstdma_ce", s_ce, 1);
    check("rstdma_ack", dma_ack, 0);
    check("rstdma_rdata", dma_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e_high(4);
    e_low(3);
    run_dma("wr0300", 1'b1, 15'h0300, 8'h99, 8'h00, -1, -1, 1'b0, 1'b1, g, a, wl, rh, bb);
    check("reserve_grant_cyc", g, 1);
    check("reserve_we_low", wl, 1);
    check("mem_0300", mem[15'h0300], 8'h99);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
